// File: rtl/writeback_queue.sv
// Writeback queue: buffers register-file writes in arrival order,
// drains one per cycle unless held, and forwards pending values.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_sel,
    input  logic [31:0]              in_dat,
    input  logic                     hold,
    output logic                     WEN,
    output logic [4:0]               wsel,
    output logic [31:0]              wdat,
    input  logic [4:0]               rsel1,
    input  logic [4:0]               rsel2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [31:0]              fwd1,
    output logic [31:0]              fwd2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    sel_q [DEPTH];
    logic [4:0]    sel_d [DEPTH];
    logic [31:0]   dat_q [DEPTH];
    logic [31:0]   dat_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;
    logic [PW-1:0] idx;

    // Handshake and drain status come from registered state only
    assign in_ready = count_q < CW'(DEPTH);
    assign WEN      = (count_q != '0) && !hold;
    assign wsel     = (count_q != '0) ? sel_q[head_q] : '0;
    assign wdat     = (count_q != '0) ? dat_q[head_q] : '0;
    assign count    = count_q;
    assign push     = in_valid && in_ready && (in_sel != 5'd0);
    assign pop      = WEN;

    // Next-state: write tail on push, advance head on pop
    always_comb begin
        sel_d   = sel_q;
        dat_d   = dat_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            sel_d[tail_q] = in_sel;
            dat_d[tail_q] = in_dat;
            tail_d        = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Forwarding: scan oldest to youngest so the youngest match wins
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (rsel1 != 5'd0 && sel_q[idx] == rsel1) begin
                    hit1 = 1'b1;
                    fwd1 = dat_q[idx];
                end
                if (rsel2 != 5'd0 && sel_q[idx] == rsel2) begin
                    hit2 = 1'b1;
                    fwd2 = dat_q[idx];
                end
            end
        end
    end

    // State register; reset drops all pending entries
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                sel_q[i] <= '0;
                dat_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_writeback_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] dat;
    } ent_t;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_sel;
    logic [31:0] in_dat;
    logic        hold;
    logic        WEN;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic [4:0]  rsel1;
    logic [4:0]  rsel2;
    logic        hit1;
    logic        hit2;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic [$clog2(DEPTH):0] count;

    int   n_vec;
    int   n_err;
    ent_t q[$];

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_dat(in_dat),
        .hold(hold),
        .WEN(WEN), .wsel(wsel), .wdat(wdat),
        .rsel1(rsel1), .rsel2(rsel2),
        .hit1(hit1), .hit2(hit2),
        .fwd1(fwd1), .fwd2(fwd2),
        .count(count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Youngest pending value for a register index, from the model queue
    task automatic lookup(input logic [4:0] r, output logic h,
                          output logic [31:0] f);
        h = 1'b0;
        f = '0;
        if (r != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].sel == r) begin
                    h = 1'b1;
                    f = q[i].dat;
                    break;
                end
            end
        end
    endtask

    // One clock: compare all outputs to the model, then advance both
    task automatic cyc();
        logic        e_wen;
        logic        e_h1, e_h2;
        logic [31:0] e_f1, e_f2;
        logic        e_rdy;
        ent_t        hd;
        hd    = (q.size() != 0) ? q[0] : '0;
        e_rdy = q.size() < DEPTH;
        e_wen = (q.size() != 0) && !hold;
        lookup(rsel1, e_h1, e_f1);
        lookup(rsel2, e_h2, e_f2);
        #2;
        chk("count", 32'(count), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("WEN", 32'(WEN), 32'(e_wen));
        chk("wsel", 32'(wsel), 32'(hd.sel));
        chk("wdat", wdat, hd.dat);
        chk("hit1", 32'(hit1), 32'(e_h1));
        chk("fwd1", fwd1, e_f1);
        chk("hit2", 32'(hit2), 32'(e_h2));
        chk("fwd2", fwd2, e_f2);
        @(posedge CLK);
        if (RST) begin
            q.delete();
        end else begin
            if (e_wen) void'(q.pop_front());
            if (in_valid && e_rdy && in_sel != 5'd0)
                q.push_back('{sel: in_sel, dat: in_dat});
        end
        #1;
    endtask

    task automatic push1(logic [4:0] s, logic [31:0] d);
        in_valid = 1'b1;
        in_sel   = s;
        in_dat   = d;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        RST      = 1'b1;
        in_valid = 1'b0;
        in_sel   = '0;
        in_dat   = '0;
        hold     = 1'b0;
        rsel1    = '0;
        rsel2    = '0;
        repeat (2) @(posedge CLK);
        #1;
        in_valid = 1'b1;
        in_sel   = 5'd9;
        in_dat   = 32'h1234;
        rsel1    = 5'd9;
        cyc();
        in_valid = 1'b0;
        RST      = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_hit1", 32'(hit1), 0);
        cyc();

        // Single push drains next cycle
        push1(5'd3, 32'hDEADBEEF);
        #1;
        chk("s35_wen", 32'(WEN), 1);
        chk("s35_wsel", 32'(wsel), 3);
        chk("s35_wdat", wdat, 32'hDEADBEEF);
        chk("s35_count", 32'(count), 1);
        cyc();
        #1;
        chk("s35_count0", 32'(count), 0);
        chk("s35_wen0", 32'(WEN), 0);
        cyc();

        // Fill while held, then drain in order
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) push1(5'(i), 32'(i * 'h11));
        #1;
        chk("s36_ready", 32'(in_ready), 0);
        chk("s36_count", 32'(count), 4);
        hold = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("s36_wen", 32'(WEN), 1);
            chk("s36_wsel", 32'(wsel), 32'(k));
            if (k == 2) chk("s36_ready1", 32'(in_ready), 1);
            cyc();
        end
        cyc();

        // Youngest match forwards
        hold = 1'b1;
        push1(5'd5, 32'hA);
        push1(5'd5, 32'hB);
        rsel1 = 5'd5;
        rsel2 = 5'd6;
        #1;
        chk("s37_hit1", 32'(hit1), 1);
        chk("s37_fwd1", fwd1, 32'hB);
        chk("s37_hit2", 32'(hit2), 0);
        chk("s37_fwd2", fwd2, 0);
        cyc();
        hold = 1'b0;
        repeat (3) cyc();
        rsel1 = '0;
        rsel2 = '0;

        // Index 0 handshakes but is dropped
        in_valid = 1'b1;
        in_sel   = 5'd0;
        in_dat   = 32'hFFFFFFFF;
        #1;
        chk("s38_ready", 32'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("s38_count", 32'(count), 0);
        chk("s38_wen", 32'(WEN), 0);
        chk("s38_hit1", 32'(hit1), 0);
        cyc();

        // Simultaneous push and pop; no same-cycle forwarding
        hold = 1'b1;
        push1(5'd1, 32'h10);
        push1(5'd2, 32'h20);
        hold     = 1'b0;
        rsel1    = 5'd7;
        in_valid = 1'b1;
        in_sel   = 5'd7;
        in_dat   = 32'h77;
        #1;
        chk("s39_hit_push", 32'(hit1), 0);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("s39_count", 32'(count), 2);
        chk("s39_hit_next", 32'(hit1), 1);
        chk("s39_fwd_next", fwd1, 32'h77);
        repeat (3) cyc();

        // Reset mid-operation drops entries without writes
        hold = 1'b1;
        push1(5'd1, 32'h1);
        push1(5'd2, 32'h2);
        push1(5'd3, 32'h3);
        rsel1 = 5'd1;
        rsel2 = 5'd3;
        RST   = 1'b1;
        cyc();
        RST  = 1'b0;
        hold = 1'b0;
        #1;
        chk("s40_count", 32'(count), 0);
        chk("s40_wen", 32'(WEN), 0);
        chk("s40_hit1", 32'(hit1), 0);
        chk("s40_hit2", 32'(hit2), 0);
        cyc();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            RST      = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 99) < 60);
            in_sel   = 5'($urandom_range(0, 7));
            in_dat   = $urandom;
            hold     = ($urandom_range(0, 99) < 35);
            rsel1    = 5'($urandom_range(0, 7));
            rsel2    = 5'($urandom_range(0, 7));
            cyc();
        end
        RST      = 1'b0;
        in_valid = 1'b0;
        hold     = 1'b0;
        repeat (6) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The module SHALL have one clock; reset is synchronous and active-high.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the number of queue entries (power of two, 2..16).
REQ-003 The module SHALL have port CLK, input, 1, the system clock; all state updates on its rising edge.
REQ-004 The module SHALL have port RST, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1, a producer write request present.
REQ-006 The module SHALL have port in_ready, output, 1, queue can accept a request this cycle.
REQ-007 The module SHALL have port in_sel, input, 5, destination register index.
REQ-008 The module SHALL have port in_dat, input, 32, destination register value.
REQ-009 The module SHALL have port hold, input, 1, suppress draining this cycle.
REQ-010 The module SHALL have port WEN, output, 1, register-file write enable.
REQ-011 The module SHALL have port wsel, output, 5, register-file write index.
REQ-012 The module SHALL have port wdat, output, 32, register-file write data.
REQ-013 The module SHALL have ports rsel1 and rsel2, input, 5 each, register-file read indices being looked up.
REQ-014 The module SHALL have ports hit1 and hit2, output, 1 each, a pending write to rsel1/rsel2 exists.
REQ-015 The module SHALL have ports fwd1 and fwd2, output, 32 each, the youngest pending value for rsel1/rsel2.
REQ-016 The module SHALL have port count, output, $clog2(DEPTH)+1, number of occupied entries.

Function
REQ-017 The module SHALL be a DEPTH-entry FIFO of {sel, dat} pairs, with entries kept in arrival order.
REQ-018 The module SHALL drive in_ready = (count < DEPTH), derived from registered state only; there is no same-cycle pop-to-push bypass when the queue is full.
REQ-019 A push SHALL occur when in_valid && in_ready and in_sel != 0; the entry is written at the tail and count increments.
REQ-020 A request with in_sel == 0 SHALL complete the handshake but SHALL NOT be enqueued, and count SHALL be unchanged by it.
REQ-021 The module SHALL drive WEN = (count != 0) && !hold, combinationally from state and hold.
REQ-022 The module SHALL drive wsel/wdat from the head entry whenever count != 0, and drive 0 on both when the queue is empty.
REQ-023 Each cycle with WEN high SHALL pop the head entry, because the register file accepts every write unconditionally.
REQ-024 On a simultaneous push and pop, count SHALL be unchanged, the new entry goes to the tail, and the head advances.
REQ-025 Head and tail pointers SHALL wrap modulo DEPTH; full and empty SHALL be determined from count, never from pointer equality alone.
REQ-026 hitN SHALL be 1 iff rselN != 0 and at least one occupied entry has sel == rselN; this is combinational and considers only entries registered before the current edge.
REQ-027 fwdN SHALL equal dat of the youngest matching entry (nearest the tail) when hitN = 1, and 0 otherwise.
REQ-028 The entry being drained this cycle SHALL still count for hit/fwd in that cycle, because the register file commits it only at the edge.
REQ-029 The incoming in_dat SHALL NOT be forwarded in the cycle it is pushed.
REQ-030 Back-to-back writes to the same index SHALL both be written to the register file in order, and the last written value SHALL be the youngest.

Reset
REQ-031 While RST = 1 at a rising edge: count = 0, head = tail = 0, and entry contents SHALL be cleared to 0.
REQ-032 During and after reset: WEN = 0, wsel = 0, wdat = 0, hit1 = hit2 = 0, fwd1 = fwd2 = 0, and in_ready = 1.
REQ-033 Reset SHALL take priority over a simultaneous push or pop; a push presented in the reset cycle is discarded.
REQ-034 Reset asserted mid-operation SHALL drop all pending entries without issuing any register-file write.

Verification
REQ-035 Scenario: push {sel=3, dat=0xDEADBEEF} into an empty queue with hold=0 -> next cycle WEN=1, wsel=3, wdat=0xDEADBEEF, count=1; the following cycle count=0 and WEN=0.
REQ-036 Scenario: hold=1, push 4 entries (sel 1..4, dat 0x11..0x44) -> in_ready=0 with count=4; release hold -> four consecutive WEN cycles with wsel 1, 2, 3, 4 in order; in_ready returns to 1 after the first pop.
REQ-037 Scenario: hold=1, push {5, 0xA}, then {5, 0xB}; set rsel1=5 -> hit1=1, fwd1=0xB; set rsel2=6 -> hit2=0, fwd2=0.
REQ-038 Scenario: push {sel=0, dat=0xFFFFFFFF} -> in_ready=1 and the handshake completes, count stays 0, WEN is never asserted; rsel1=0 -> hit1=0.
REQ-039 Scenario: with count=2 and hold=0, push {7, 0x77} -> count stays 2 (simultaneous push and pop); rsel1=7 shows hit1=0 in the push cycle and hit1=1 in the next cycle.
REQ-040 Scenario: hold=1, 3 entries queued, assert RST for one cycle -> count=0, WEN=0, hit1=hit2=0, and no register-file write occurs at any point.
